// File: rtl/ps2_key_event_if.sv
// Bundles the receiver-side pop handshake and the event-side valid/ready stream of ps2_key_event.
// The master modport is the ps2_key_event view; slave is the surrounding receiver/consumer view.
interface ps2_key_event_if;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       ps2_nextdata_n;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_repeat;
    logic [7:0] key_count;
    logic       key_held;
    logic [1:0] err_sticky;

    modport master (
        input  ps2_data, ps2_ready, ps2_overflow, evt_ready,
        output ps2_nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_repeat,
        output key_count, key_held, err_sticky
    );

    modport slave (
        output ps2_data, ps2_ready, ps2_overflow, evt_ready,
        input  ps2_nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_repeat,
        input  key_count, key_held, err_sticky
    );
endinterface

// File: rtl/ps2_key_event.sv
// Folds PS/2 E0/F0 prefixes into key events, tracks typematic repeats and key count, buffers events in a FIFO.
// Optional macro PS2_TYPEMATIC_FILTER_EN: repeat makes are not pushed into the event FIFO.
//
// state  | meaning
// IDLE   | wait for a receiver byte, latch it
// POP    | strobe nextdata_n low, decode latched byte
// SETTLE | give the receiver a cycle to update ready/data
module ps2_key_event #(
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = 3
) (
    input  logic            clk,
    input  logic            rst,
    ps2_key_event_if.master bus
);

    typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      byte_r;
    logic            ext_f;
    logic            brk_f;
    logic            held_ext;
    logic [7:0]      held_code;
    logic            key_held_r;
    logic [7:0]      key_count_r;
    logic [1:0]      err_r;
    logic [10:0]     mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [10:0]     head;

    logic            decode;
    logic            is_prefix;
    logic            is_code;
    logic            same_key;
    logic            rep;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            push_ok;
    logic            drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.ps2_ready) state_nxt = POP;
            POP:     state_nxt = SETTLE;
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign decode    = (state == POP);
    assign is_prefix = (byte_r == 8'hE0) || (byte_r == 8'hF0) || (byte_r == 8'hE1);
    assign is_code   = decode && !is_prefix;
    assign same_key  = ({ext_f, byte_r} == {held_ext, held_code});
    assign rep       = !brk_f && key_held_r && same_key;

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign push = is_code && !rep;
`else
    assign push = is_code;
`endif

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = bus.evt_ready && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_r      <= '0;
            ext_f       <= 1'b0;
            brk_f       <= 1'b0;
            held_ext    <= 1'b0;
            held_code   <= '0;
            key_held_r  <= 1'b0;
            key_count_r <= '0;
            err_r       <= '0;
        end else begin
            if (state == IDLE && bus.ps2_ready) byte_r <= bus.ps2_data;
            if (decode) begin
                if (byte_r == 8'hE0) ext_f <= 1'b1;
                else if (byte_r == 8'hF0) brk_f <= 1'b1;
                else if (byte_r != 8'hE1) begin
                    ext_f <= 1'b0;
                    brk_f <= 1'b0;
                end
            end
            if (is_code && !brk_f && !rep) begin
                held_ext    <= ext_f;
                held_code   <= byte_r;
                key_held_r  <= 1'b1;
                key_count_r <= key_count_r + 8'd1;
            end
            if (is_code && brk_f && same_key) key_held_r <= 1'b0;
            if (drop) err_r[1] <= 1'b1;
            if (bus.ps2_overflow) err_r[0] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= {ext_f, brk_f, rep, byte_r};
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign head               = mem[rd_ptr[AW-1:0]];
    assign bus.ps2_nextdata_n = !decode;
    assign bus.evt_valid      = !empty;
    assign bus.evt_ext        = head[10];
    assign bus.evt_break      = head[9];
    assign bus.evt_repeat     = head[8];
    assign bus.evt_code       = head[7:0];
    assign bus.key_count      = key_count_r;
    assign bus.key_held       = key_held_r;
    assign bus.err_sticky     = err_r;

endmodule

// File: tb/tb_ps2_key_event.sv
// Bench for ps2_key_event: byte-level receiver model, event scoreboard, table-driven key sequences.
`timescale 1ns/1ps
module tb_ps2_key_event;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_event_if bus();

    ps2_key_event #(.FIFO_DEPTH(8), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic       rep;
        logic [7:0] code;
    } evt_t;

    typedef struct {
        logic [7:0] b;
        bit         has_evt;
        logic       ext;
        logic       brk;
        logic       rep;
        logic [7:0] cnt;
        logic       held;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         pops   = 0;
    logic [7:0] rx_q[$];
    evt_t       sb[$];
    evt_t       mon_exp;
    evt_t       mon_got;
    vec_t       vecs[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic void expect_evt(logic ext, logic brk, logic rep, logic [7:0] code);
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (rep) return;
`endif
        sb.push_back('{ext, brk, rep, code});
    endfunction

    // Receiver model and event consumer, both on the falling edge.
    initial begin
        bus.ps2_data  = 8'h00;
        bus.ps2_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.ps2_nextdata_n == 1'b0) begin
                    pulses++;
                    if (rx_q.size() != 0) void'(rx_q.pop_front());
                end
                if (bus.evt_valid && bus.evt_ready) begin
                    pops++;
                    checks++;
                    mon_got = '{bus.evt_ext, bus.evt_break, bus.evt_repeat, bus.evt_code};
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL evt_unexpected got=%03h want=none", mon_got);
                    end else begin
                        mon_exp = sb.pop_front();
                        if (mon_got !== mon_exp) begin
                            errors++;
                            $display("FAIL evt_fields got=%03h want=%03h", mon_got, mon_exp);
                        end
                    end
                end
            end
            bus.ps2_ready = (rx_q.size() != 0);
            bus.ps2_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        end
    end

    task automatic wait_rx_empty(int budget);
        int n = 0;
        while (rx_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (rx_q.size() != 0) chk("rx_drain_timeout", rx_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_sb(string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, sb.size(), 0);
    endtask

    task automatic send(logic [7:0] b);
        @(posedge clk);
        #1;
        rx_q.push_back(b);
        wait_rx_empty(100);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx_q.delete();
        sb.delete();
        repeat (2) @(negedge clk);
        chk("rst_nextdata_n", bus.ps2_nextdata_n, 1);
        chk("rst_evt_valid", bus.evt_valid, 0);
        chk("rst_key_count", bus.key_count, 0);
        chk("rst_key_held", bus.key_held, 0);
        chk("rst_err_sticky", bus.err_sticky, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        pulses = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        bus.ps2_overflow = 1'b0;
        bus.evt_ready    = 1'b1;

        //            byte   ev ext brk rep cnt  held
        vecs.push_back('{8'h1C, 1, 0, 0, 0, 8'd1, 1});
        vecs.push_back('{8'hF0, 0, 0, 0, 0, 8'd1, 1});
        vecs.push_back('{8'h1C, 1, 0, 1, 0, 8'd1, 0});
        vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'd1, 0});
        vecs.push_back('{8'h75, 1, 1, 0, 0, 8'd2, 1});
        vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'd2, 1});
        vecs.push_back('{8'hF0, 0, 0, 0, 0, 8'd2, 1});
        vecs.push_back('{8'h75, 1, 1, 1, 0, 8'd2, 0});
        vecs.push_back('{8'h1C, 1, 0, 0, 0, 8'd3, 1});
        vecs.push_back('{8'h1C, 1, 0, 0, 1, 8'd3, 1});
        vecs.push_back('{8'h1C, 1, 0, 0, 1, 8'd3, 1});
        vecs.push_back('{8'hF0, 0, 0, 0, 0, 8'd3, 1});
        vecs.push_back('{8'h1C, 1, 0, 1, 0, 8'd3, 0});
        vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'd3, 0});
        vecs.push_back('{8'hE1, 0, 0, 0, 0, 8'd3, 0});
        vecs.push_back('{8'h6B, 1, 1, 0, 0, 8'd4, 1});
        vecs.push_back('{8'hF0, 0, 0, 0, 0, 8'd4, 1});
        vecs.push_back('{8'h1C, 1, 0, 1, 0, 8'd4, 1});
        vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'd4, 1});
        vecs.push_back('{8'h6B, 1, 1, 0, 1, 8'd4, 1});
        vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'd4, 1});
        vecs.push_back('{8'hF0, 0, 0, 0, 0, 8'd4, 1});
        vecs.push_back('{8'h6B, 1, 1, 1, 0, 8'd4, 0});

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].has_evt) expect_evt(vecs[i].ext, vecs[i].brk, vecs[i].rep, vecs[i].b);
            send(vecs[i].b);
            chk($sformatf("key_count_v%0d", i), bus.key_count, vecs[i].cnt);
            chk($sformatf("key_held_v%0d", i), bus.key_held, vecs[i].held);
        end
        wait_sb("table_events_drained");
        chk("nextdata_pulses", pulses, vecs.size());

        // FIFO overflow: 9 distinct makes with consumer stalled
        do_reset();
        bus.evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) expect_evt(1'b0, 1'b0, 1'b0, 8'(32'h20 + i));
            send(8'(32'h20 + i));
        end
        chk("ovf_err_sticky", bus.err_sticky, 2'b10);
        chk("ovf_key_count", bus.key_count, 9);
        chk("ovf_evt_valid", bus.evt_valid, 1);
        p0 = pops;
        @(posedge clk);
        #1;
        bus.evt_ready = 1'b1;
        wait_sb("ovf_events_drained");
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_pop_count", pops - p0, 8);
        chk("ovf_empty_after", bus.evt_valid, 0);

        // Reset between E0 and the code byte discards the prefix
        send(8'hE0);
        do_reset();
        expect_evt(1'b0, 1'b0, 1'b0, 8'h75);
        send(8'h75);
        wait_sb("rst_prefix_event");
        chk("rst_prefix_count", bus.key_count, 1);

        // key_count wrap after 256 non-repeat makes
        do_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 255; i++) begin
            expect_evt(1'b0, 1'b0, 1'b0, (i % 2 == 1) ? 8'h11 : 8'h10);
            rx_q.push_back((i % 2 == 1) ? 8'h11 : 8'h10);
        end
        wait_rx_empty(2000);
        chk("count_255", bus.key_count, 255);
        wait_sb("wrap_events_drained");
        expect_evt(1'b0, 1'b0, 1'b0, 8'h11);
        send(8'h11);
        chk("count_wrap_0", bus.key_count, 0);
        wait_sb("wrap_last_event");

        // Receiver overflow pulse is sticky until reset
        @(posedge clk);
        #1;
        bus.ps2_overflow = 1'b1;
        @(posedge clk);
        #1;
        bus.ps2_overflow = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rx_ovf_sticky", bus.err_sticky, 2'b01);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
